// File: rtl/ff_ctrl_pkg.sv
// Shared definitions for the RS flip-flop access controller:
// opcodes, FSM state encoding and counter sizing helpers.
package ff_ctrl_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_RST  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Counter only has to hold (max phase length - 1).
    function automatic int cnt_width(input int pulse_cyc,
                                     input int settle_cyc);
        int m;
        m = (pulse_cyc > settle_cyc) ? pulse_cyc : settle_cyc;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // Value Q must reach once the command has been applied.
    function automatic logic op_target(input logic [1:0] op,
                                       input logic       q);
        logic t;
        unique case (op)
            OP_SET:  t = 1'b1;
            OP_RST:  t = 1'b0;
            OP_TGL:  t = ~q;
            default: t = q;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/rs_ff_access_ctrl_rr_arb2.sv
// Two-input round-robin arbiter with a served-requester mask.
// The pointer only flips when both inputs actually contend.
module rr_arb2 (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       take,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic       ptr;
    logic [1:0] elig;

    assign elig = req & ~mask;

    // Pick the favoured requester on contention, else the lone one.
    always_comb begin
        gnt_valid = |elig;
        gnt_id    = 1'b0;
        if (&elig) begin
            gnt_id = ptr;
        end else begin
            gnt_id = elig[1];
        end
    end

    // Hand priority to the loser after a contended grant.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            ptr <= 1'b0;
        end else if (take && (&elig)) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/rs_ff_access_ctrl.sv
// Shares one RS flip-flop between two requesters: arbitrates,
// pulses S or R, waits for settling and returns the sampled Q.
module rs_ff_access_ctrl
    import ff_ctrl_pkg::*;
#(
    parameter int PULSE_CYC  = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       req0,
    input  logic [1:0] op0,
    output logic       ack0,
    output logic       rdata0,
    input  logic       req1,
    input  logic [1:0] op1,
    output logic       ack1,
    output logic       rdata1,
    output logic       ff_s,
    output logic       ff_r,
    input  logic       ff_q,
    output logic       busy,
    output logic       err
);

    localparam int CW = cnt_width(PULSE_CYC, SETTLE_CYC);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LD =
        CW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          tgt;
    logic          tgt_n;
    logic          id;
    logic          id_n;
    logic          served;
    logic          served_id;
    logic [1:0]    mask;
    logic          take;
    logic          gnt_valid;
    logic          gnt_id;
    logic [1:0]    sel_op;

    // The requester just acked sits out one IDLE cycle.
    assign mask   = served ? (served_id ? 2'b10 : 2'b01) : 2'b00;
    assign take   = (state == IDLE) && gnt_valid;
    assign sel_op = gnt_id ? op1 : op0;

    rr_arb2 u_arb (
        .clk       (clk),
        .clear_n   (clear_n),
        .req       ({req1, req0}),
        .mask      (mask),
        .take      (take),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Next-state logic: accept, pulse, settle, respond.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tgt_n   = tgt;
        id_n    = id;
        unique case (state)
            IDLE: begin
                if (gnt_valid) begin
                    id_n  = gnt_id;
                    tgt_n = op_target(sel_op, ff_q);
                    if (sel_op == OP_HOLD) begin
                        state_n = RESP;
                    end else begin
                        state_n = DRIVE;
                        cnt_n   = PULSE_LD;
                    end
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    if (SETTLE_CYC == 0) begin
                        state_n = RESP;
                    end else begin
                        state_n = SETTLE;
                        cnt_n   = SETTLE_LD;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_n = RESP;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
            cnt   <= '0;
            tgt   <= 1'b0;
            id    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            tgt   <= tgt_n;
            id    <= id_n;
        end
    end

    // Remember who was served for the following IDLE cycle.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            served    <= 1'b0;
            served_id <= 1'b0;
        end else begin
            served    <= (state == RESP);
            served_id <= id;
        end
    end

    // Registered Moore outputs; Q is sampled as RESP is presented.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            ff_s   <= 1'b0;
            ff_r   <= 1'b0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            rdata0 <= 1'b0;
            rdata1 <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            ff_s   <= (state == DRIVE) && tgt;
            ff_r   <= (state == DRIVE) && !tgt;
            ack0   <= (state == RESP) && !id;
            ack1   <= (state == RESP) && id;
            rdata0 <= (state == RESP) && !id && ff_q;
            rdata1 <= (state == RESP) && id && ff_q;
            busy   <= (state != IDLE);
            err    <= (state == RESP) && (ff_q != tgt);
        end
    end

endmodule
